hs32_alu_arb: RTL and testbench
===============================

// Module: hs32_alu_arb
// PURPOSE
//  Two-requester arbiter sharing the single hs32_alu between the execute stage (req 0) and the
//  address/branch unit (req 1). Grants at most one op per cycle, drives the ALU operand/control
//  ports, captures each result into a per-requester response slot, and supports a lock so that
//  multi-op sequences (e.g. 64-bit add via cen) are not interleaved and their NZCV flags are not clobbered.
// PARAMETERS
//  ROUND_ROBIN  1  1: round-robin between requesters; 0: fixed priority, req 0 wins
//  LOCK_MAX     8  max consecutive locked grants before the lock is forcibly released (>=1)
// PORTS
//  clk          in   1            clock
//  reset        in   1            asynchronous, active-high reset
//  req_valid_i  in   2            per-requester op valid
//  req_ready_o  out  2            per-requester grant (op accepted this cycle)
//  req_lock_i   in   2            hold ownership after this op
//  req_a_i      in   2x32         operand A per requester
//  req_b_i      in   2x32         operand B per requester
//  req_ctl_i    in   2xhs32_aluctl  ALU control per requester
//  alu_a_o      out  32           to ALU a_i
//  alu_b_o      out  32           to ALU b_i
//  alu_ctl_o    out  hs32_aluctl  to ALU ctl_i
//  alu_valid_o  out  1            to ALU valid_i (gates flag write)
//  alu_out_i    in   32           from ALU out (combinational)
//  alu_flags_i  in   4            from ALU flags_o (NZCV, registered in ALU)
//  rsp_valid_o  out  2            per-requester response slot full
//  rsp_ready_i  in   2            per-requester response consumed
//  rsp_data_o   out  2x32         captured result
//  rsp_flags_o  out  2x4          alu_flags_i while slot full (post-op flags)
// BEHAVIOUR
//  - Reset: req_ready_o=0, alu_valid_o=0, alu_a/b/ctl_o=0, rsp_valid_o=0, rsp_data_o=0, lock free,
//    lock count 0, RR pointer -> req 0 preferred. Reset mid-lock or with full slots discards all.
//  - Eligible(i) = req_valid_i[i] & (~rsp_valid_o[i] | rsp_ready_i[i]) & (lock free | owner==i).
//  - Arbitration (comb): one grant max. Lock owner, if any, is the only candidate. Else both
//    eligible -> ROUND_ROBIN ? requester not granted last : req 0. req_ready_o = grant one-hot.
//  - On grant g: alu_a/b/ctl_o = req_*_i[g], alu_valid_o=1 same cycle; no grant -> alu_valid_o=0,
//    alu_ctl_o.fwe forced 0, operands held at last value.
//  - Capture: on grant edge rsp_data_o[g] <= alu_out_i, rsp_valid_o[g] <= 1. Latency 1 cycle
//    accept->response. rsp_valid[i] & rsp_ready[i] without new grant clears slot; with grant to i
//    same cycle, slot reloads (stays 1, new data). Full slot with rsp_ready=0 blocks i only.
//  - Flags: ALU updates NZCV on the grant edge; rsp_flags_o[i] = alu_flags_i, valid only in first
//    response cycle before any later fwe grant; requesters needing flags must lock.
//  - Lock FSM: FREE -> OWNED(g) on grant with req_lock_i[g]=1, cnt=1. OWNED: grant with lock=1
//    cnt++; grant with lock=0 -> FREE. cnt==LOCK_MAX on a locked grant -> FREE next cycle
//    (forced release), RR pointer moves to other requester. Owner idle does not release.
//  - RR pointer updates only on a grant. cen carry comes from the last ALU op, whoever issued it.
// TESTING
//  - Reset, req0 valid a=5 b=3 ctl add -> ready0=1 same cycle; next cycle rsp_valid0=1 data=8.
//  - Both valid every cycle, rsp_ready=11, RR=1 -> grants 0,1,0,1; FIXED -> grants 0,0,0.
//  - req0 locks 2 ops (0xFFFFFFFF+1, then 0+0 cen), req1 valid throughout -> req1 blocked until
//    unlocked op; results 0 then 1 (carry chained), flags after op2 NZCV=0000.
//  - rsp_ready0=0 with slot full, req0 valid -> ready0=0, req1 still granted; raise rsp_ready0
//    with req0 valid -> same-cycle drain+reload, rsp_valid0 stays 1.
//  - Lock held LOCK_MAX=8 grants -> 9th grant goes to req1 if valid.
//  - Assert reset mid-lock with both slots full -> all outputs 0 immediately; lock free after.

Source files
------------

// File: rtl/hs32_alu_arb.sv
// hs32_alu_arb: shares one hs32 ALU between two requesters with lock, round-robin/fixed arbitration and response slots
package hs32_pkg;
  typedef struct packed {
    logic [2:0] op;
    logic       cen;
    logic       fwe;
  } hs32_aluctl;
endpackage

module hs32_alu_arb
  import hs32_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int LOCK_MAX    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0]       req_lock_i,
  input  logic [1:0][31:0] req_a_i,
  input  logic [1:0][31:0] req_b_i,
  input  hs32_aluctl [1:0] req_ctl_i,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  output hs32_aluctl       alu_ctl_o,
  output logic             alu_valid_o,
  input  logic [31:0]      alu_out_i,
  input  logic [3:0]       alu_flags_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [1:0][31:0] rsp_data_o,
  output logic [1:0][3:0]  rsp_flags_o
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic locked, owner, pref, g, keep_lock;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] elig;
  logic [31:0] a_q, b_q;
  hs32_aluctl ctl_q, ctl_idle;

  // reset gates the grant so every ALU-facing output reads 0 while reset is held
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid_i[i] & (~rsp_valid_o[i] | rsp_ready_i[i]) & (~locked | owner == 1'(i)) & ~reset;
      rsp_flags_o[i] = rsp_valid_o[i] ? alu_flags_i : 4'b0;
    end
    g = locked ? owner : (&elig ? (ROUND_ROBIN != 0 ? pref : 1'b0) : elig[1]);
    req_ready_o = elig[g] ? (2'b01 << g) : 2'b00;
    alu_valid_o = |req_ready_o;
    ctl_idle = ctl_q;
    ctl_idle.fwe = 1'b0;
    alu_a_o = alu_valid_o ? req_a_i[g] : a_q;
    alu_b_o = alu_valid_o ? req_b_i[g] : b_q;
    alu_ctl_o = alu_valid_o ? req_ctl_i[g] : ctl_idle;
    cnt_nxt = locked ? cnt + 1'b1 : CW'(1);
    keep_lock = req_lock_i[g] && cnt_nxt < CW'(LOCK_MAX);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      locked <= 1'b0;
      owner <= 1'b0;
      pref <= 1'b0;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
      ctl_q <= '0;
      rsp_valid_o <= '0;
      rsp_data_o <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (rsp_ready_i[i]) rsp_valid_o[i] <= 1'b0;
      if (alu_valid_o) begin
        rsp_valid_o[g] <= 1'b1;
        rsp_data_o[g] <= alu_out_i;
        a_q <= alu_a_o;
        b_q <= alu_b_o;
        ctl_q <= alu_ctl_o;
        pref <= ~g;
        owner <= g;
        locked <= keep_lock;
        cnt <= keep_lock ? cnt_nxt : '0;
      end
    end
endmodule

// File: tb/tb_hs32_alu_arb.sv
// tb_hs32_alu_arb: directed vectors plus randomized traffic against a behavioural model, for round-robin and fixed-priority instances
module tb_hs32_alu_arb;
  import hs32_pkg::*;
  localparam int LM = 8;
  localparam hs32_aluctl ADD = '{op: 3'd0, cen: 1'b0, fwe: 1'b1};
  localparam hs32_aluctl ADC = '{op: 3'd0, cen: 1'b1, fwe: 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] req_valid, req_lock, rsp_ready;
  logic [1:0][31:0] req_a, req_b;
  hs32_aluctl [1:0] req_ctl;
  logic [1:0] ready [2];
  logic [1:0] rsp_valid [2];
  logic alu_valid [2];
  logic [31:0] alu_a [2];
  logic [31:0] alu_b [2];
  logic [31:0] alu_out [2];
  logic [3:0] alu_nf [2];
  logic [3:0] alu_flags [2];
  hs32_aluctl alu_ctl [2];
  logic [1:0][31:0] rsp_data [2];
  logic [1:0][3:0] rsp_flags [2];

  int checks = 0, errs = 0;

  // returns {NZCV, result}; carry-in for cen comes from the previous flags
  function automatic logic [35:0] alu_f(logic [31:0] a, logic [31:0] b, hs32_aluctl c, logic [3:0] f);
    logic [32:0] s;
    logic [31:0] bb;
    logic [3:0] nf;
    bb = (c.op == 3'd1) ? ~b : b;
    case (c.op)
      3'd0, 3'd1: s = {1'b0, a} + {1'b0, bb} + 33'(c.cen ? f[1] : (c.op == 3'd1));
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      3'd4: s = {1'b0, a ^ b};
      default: s = {1'b0, b};
    endcase
    nf = {s[31], s[31:0] == 32'd0, s[32], (c.op <= 3'd1) && (a[31] == bb[31]) && (s[31] != a[31])};
    return {nf, s[31:0]};
  endfunction

  hs32_alu_arb #(.ROUND_ROBIN(1), .LOCK_MAX(LM)) dut_rr (
    .clk(clk), .reset(rst), .req_valid_i(req_valid), .req_ready_o(ready[0]), .req_lock_i(req_lock),
    .req_a_i(req_a), .req_b_i(req_b), .req_ctl_i(req_ctl), .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]),
    .alu_ctl_o(alu_ctl[0]), .alu_valid_o(alu_valid[0]), .alu_out_i(alu_out[0]), .alu_flags_i(alu_flags[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[0]), .rsp_flags_o(rsp_flags[0])
  );

  hs32_alu_arb #(.ROUND_ROBIN(0), .LOCK_MAX(LM)) dut_fx (
    .clk(clk), .reset(rst), .req_valid_i(req_valid), .req_ready_o(ready[1]), .req_lock_i(req_lock),
    .req_a_i(req_a), .req_b_i(req_b), .req_ctl_i(req_ctl), .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]),
    .alu_ctl_o(alu_ctl[1]), .alu_valid_o(alu_valid[1]), .alu_out_i(alu_out[1]), .alu_flags_i(alu_flags[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[1]), .rsp_flags_o(rsp_flags[1])
  );

  for (genvar k = 0; k < 2; k++) begin : g_alu
    always_comb {alu_nf[k], alu_out[k]} = alu_f(alu_a[k], alu_b[k], alu_ctl[k], alu_flags[k]);
    always_ff @(posedge clk or posedge rst)
      if (rst) alu_flags[k] <= '0;
      else if (alu_valid[k] && alu_ctl[k].fwe) alu_flags[k] <= alu_nf[k];
  end

  bit mv [2][2];
  logic [31:0] md [2][2];
  logic [3:0] mf [2];
  int mown [2], mcnt [2], mpref [2];
  logic [31:0] mla [2], mlb [2];
  hs32_aluctl mlc [2];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        mv[k][i] = 1'b0;
        md[k][i] = '0;
      end
      mf[k] = '0;
      mown[k] = -1;
      mcnt[k] = 0;
      mpref[k] = 0;
      mla[k] = '0;
      mlb[k] = '0;
      mlc[k] = '0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // checks both instances against the model mid-cycle, then advances the model over the coming edge
  task automatic cyc();
    int g;
    bit e0, e1;
    logic [35:0] r;
    hs32_aluctl ic;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e0 = req_valid[0] && (!mv[k][0] || rsp_ready[0]) && mown[k] != 1;
      e1 = req_valid[1] && (!mv[k][1] || rsp_ready[1]) && mown[k] != 0;
      g = (e0 && e1) ? (k == 0 ? mpref[k] : 0) : e0 ? 0 : e1 ? 1 : -1;
      chk($sformatf("ready%0d", k), ready[k], g < 0 ? 0 : 1 << g);
      chk($sformatf("alu_valid%0d", k), alu_valid[k], g >= 0);
      if (g >= 0) begin
        chk("alu_a", alu_a[k], req_a[g]);
        chk("alu_b", alu_b[k], req_b[g]);
        chk("alu_ctl", alu_ctl[k], req_ctl[g]);
      end else begin
        ic = mlc[k];
        ic.fwe = 1'b0;
        chk("alu_a_hold", alu_a[k], mla[k]);
        chk("alu_b_hold", alu_b[k], mlb[k]);
        chk("alu_ctl_idle", alu_ctl[k], ic);
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rsp_valid%0d_%0d", k, i), rsp_valid[k][i], mv[k][i]);
        if (mv[k][i]) chk($sformatf("rsp_data%0d_%0d", k, i), rsp_data[k][i], md[k][i]);
        chk($sformatf("rsp_flags%0d_%0d", k, i), rsp_flags[k][i], mv[k][i] ? mf[k] : 4'h0);
      end
      for (int i = 0; i < 2; i++)
        if (rsp_ready[i]) mv[k][i] = 1'b0;
      if (g >= 0) begin
        r = alu_f(req_a[g], req_b[g], req_ctl[g], mf[k]);
        mv[k][g] = 1'b1;
        md[k][g] = r[31:0];
        if (req_ctl[g].fwe) mf[k] = r[35:32];
        mla[k] = req_a[g];
        mlb[k] = req_b[g];
        mlc[k] = req_ctl[g];
        mpref[k] = 1 - g;
        if (req_lock[g]) begin
          mcnt[k] = (mown[k] < 0) ? 1 : mcnt[k] + 1;
          mown[k] = (mcnt[k] >= LM) ? -1 : g;
          if (mown[k] < 0) mcnt[k] = 0;
        end else begin
          mown[k] = -1;
          mcnt[k] = 0;
        end
      end
    end
  endtask

  task automatic chk_zero(int k);
    chk("rst_ready", ready[k], 0);
    chk("rst_alu_valid", alu_valid[k], 0);
    chk("rst_alu_a", alu_a[k], 0);
    chk("rst_alu_b", alu_b[k], 0);
    chk("rst_alu_ctl", alu_ctl[k], 0);
    chk("rst_rsp_valid", rsp_valid[k], 0);
    chk("rst_rsp_data", rsp_data[k], 0);
    chk("rst_rsp_flags", rsp_flags[k], 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    req_ctl = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] v, l, rr;
    logic [31:0] a0, b0, a1, b1;
    hs32_aluctl c0, c1;
    logic [1:0] e_rdy, e_rv;
    logic [31:0] e_d0;
    logic [3:0] e_f0;
  } vec_t;
  vec_t tv [12];

  initial begin
    tv[0]  = '{2'b11, 2'b00, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, ADD, ADD, 2'b01, 2'b00, 32'd0, 4'h0};
    tv[1]  = '{2'b11, 2'b00, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, ADD, ADD, 2'b10, 2'b01, 32'd2, 4'h0};
    tv[2]  = '{2'b11, 2'b00, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, ADD, ADD, 2'b01, 2'b10, 32'd0, 4'h0};
    tv[3]  = '{2'b11, 2'b00, 2'b11, 32'd1, 32'd1, 32'd2, 32'd2, ADD, ADD, 2'b10, 2'b01, 32'd2, 4'h0};
    tv[4]  = '{2'b01, 2'b00, 2'b11, 32'd5, 32'd3, 32'd2, 32'd2, ADD, ADD, 2'b01, 2'b10, 32'd0, 4'h0};
    tv[5]  = '{2'b10, 2'b00, 2'b11, 32'd5, 32'd3, 32'd2, 32'd2, ADD, ADD, 2'b10, 2'b01, 32'd8, 4'h0};
    tv[6]  = '{2'b11, 2'b01, 2'b11, 32'hFFFF_FFFF, 32'd1, 32'd7, 32'd7, ADD, ADD, 2'b01, 2'b10, 32'd0, 4'h0};
    tv[7]  = '{2'b11, 2'b00, 2'b11, 32'd0, 32'd0, 32'd7, 32'd7, ADC, ADD, 2'b01, 2'b01, 32'd0, 4'b0110};
    tv[8]  = '{2'b10, 2'b00, 2'b10, 32'd0, 32'd0, 32'd7, 32'd7, ADD, ADD, 2'b10, 2'b01, 32'd1, 4'h0};
    tv[9]  = '{2'b11, 2'b00, 2'b10, 32'd4, 32'd4, 32'd9, 32'd1, ADD, ADD, 2'b10, 2'b11, 32'd1, 4'h0};
    tv[10] = '{2'b01, 2'b00, 2'b01, 32'd4, 32'd4, 32'd9, 32'd1, ADD, ADD, 2'b01, 2'b11, 32'd1, 4'h0};
    tv[11] = '{2'b00, 2'b00, 2'b00, 32'd4, 32'd4, 32'd9, 32'd1, ADD, ADD, 2'b00, 2'b11, 32'd8, 4'h0};

    req_valid = 2'b11;
    req_lock = 2'b11;
    rsp_ready = 2'b11;
    req_a = '0;
    req_b = '0;
    req_ctl = '0;
    #3;
    for (int k = 0; k < 2; k++) chk_zero(k);

    do_reset();
    for (int n = 0; n < 12; n++) begin
      req_valid = tv[n].v;
      req_lock = tv[n].l;
      rsp_ready = tv[n].rr;
      req_a[0] = tv[n].a0;
      req_b[0] = tv[n].b0;
      req_a[1] = tv[n].a1;
      req_b[1] = tv[n].b1;
      req_ctl[0] = tv[n].c0;
      req_ctl[1] = tv[n].c1;
      cyc();
      chk($sformatf("tv%0d_ready", n), ready[0], tv[n].e_rdy);
      chk($sformatf("tv%0d_rsp_valid", n), rsp_valid[0], tv[n].e_rv);
      if (tv[n].e_rv[0]) begin
        chk($sformatf("tv%0d_data0", n), rsp_data[0][0], tv[n].e_d0);
        chk($sformatf("tv%0d_flags0", n), rsp_flags[0][0], tv[n].e_f0);
      end
      tick();
    end

    do_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_ctl[0] = ADD;
    req_ctl[1] = ADD;
    for (int n = 0; n < 4; n++) begin
      cyc();
      chk("fixed_ready", ready[1], 2'b01);
      chk("rr_ready", ready[0], (n % 2) ? 2'b10 : 2'b01);
      tick();
    end

    do_reset();
    req_valid = 2'b11;
    req_lock = 2'b01;
    rsp_ready = 2'b11;
    req_ctl[0] = ADC;
    req_ctl[1] = ADD;
    for (int n = 0; n <= LM; n++) begin
      req_a[0] = $urandom;
      req_b[0] = $urandom;
      cyc();
      chk($sformatf("lockmax_ready%0d", n), ready[0], n < LM ? 2'b01 : 2'b10);
      tick();
    end

    do_reset();
    req_valid = 2'b11;
    req_lock = 2'b10;
    req_a[0] = 32'd11;
    req_a[1] = 32'd22;
    req_ctl[0] = ADD;
    req_ctl[1] = ADD;
    cyc();
    tick();
    cyc();
    tick();
    cyc();
    chk("mid_lock_full", rsp_valid[0], 2'b11);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk_zero(k);
    tick();
    rst = 1'b0;
    model_reset();
    req_valid = 2'b01;
    req_lock = 2'b00;
    cyc();
    chk("post_reset_lock_free", ready[0], 2'b01);
    tick();

    do_reset();
    for (int n = 0; n < 500; n++) begin
      req_valid = 2'($urandom);
      req_lock = (n < 250) ? 2'($urandom) : 2'($urandom_range(0, 3) == 0);
      rsp_ready = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        req_a[i] = $urandom;
        req_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_ctl[i] = '{op: 3'($urandom_range(0, 5)), cen: 1'($urandom), fwe: 1'($urandom)};
      end
      cyc();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
